// File: rtl/paddle_ai_if.sv
// Signal bundle between the AI paddle controller and its environment:
// ball and paddle geometry go in, the move command and state come out.
interface paddle_ai_if;
  logic       enable;
  logic       game_end;
  logic [9:0] ball_x;
  logic       ball_approaching;
  logic [9:0] paddle_x1;
  logic [9:0] paddle_x2;
  logic [1:0] paddle_cmd;
  logic [1:0] ai_state;

  // Level signals only: inputs are sampled on every clock edge, and the outputs are registered.
  modport master (
    output enable, game_end, ball_x, ball_approaching, paddle_x1, paddle_x2,
    input  paddle_cmd, ai_state
  );

  modport slave (
    input  enable, game_end, ball_x, ball_approaching, paddle_x1, paddle_x2,
    output paddle_cmd, ai_state
  );
endinterface

// File: rtl/paddle_ai_ctrl.sv
// Computer opponent for one paddle: steers the paddle centre toward the ball,
// or toward the screen centre, and re-decides once per reaction period.
module paddle_ai_ctrl #(
  parameter int SCREEN_W     = 640,
  parameter int CENTER_X     = 320,
  parameter int DEADBAND     = 4,
  parameter int STOP_BAND    = 1,
  parameter int REACT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  paddle_ai_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_MOVE_L = 2'd2,
    ST_MOVE_R = 2'd3
  } ai_state_e;

  localparam int CW = (REACT_CYCLES > 1) ? $clog2(REACT_CYCLES) : 1;
  localparam logic [CW-1:0]     COUNT_LAST = CW'(REACT_CYCLES - 1);
  localparam logic signed [11:0] DB_POS    = 12'(DEADBAND);
  localparam logic signed [11:0] DB_NEG    = -12'(DEADBAND);
  localparam logic signed [11:0] SB_POS    = 12'(STOP_BAND);
  localparam logic signed [11:0] SB_NEG    = -12'(STOP_BAND);
  localparam logic [9:0]         WALL_R    = 10'(SCREEN_W);
  localparam logic [9:0]         REST_X    = 10'(CENTER_X);

  ai_state_e     state_q, state_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [CW-1:0] count_q, count_d;

  logic               tick;
  logic [10:0]        centre;
  logic [9:0]         target;
  logic signed [11:0] err;
  logic               force_idle;

  // Centre is formed at 11 bits so x1 + x2 cannot wrap before the halving.
  always_comb begin
    centre     = ({1'b0, bus.paddle_x1} + {1'b0, bus.paddle_x2}) >> 1;
    target     = bus.ball_approaching ? bus.ball_x : REST_X;
    err        = $signed({2'b00, target}) - $signed({1'b0, centre});
    tick       = (count_q == COUNT_LAST);
    force_idle = !bus.enable || bus.game_end;
  end

  always_comb begin
    state_d = state_q;
    if (force_idle) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_HOLD;
        ST_HOLD: begin
          if (tick) begin
            if (err > DB_POS)      state_d = ST_MOVE_R;
            else if (err < DB_NEG) state_d = ST_MOVE_L;
          end
        end
        // Wall stop beats the tick decision and needs no tick.
        ST_MOVE_R: begin
          if (bus.paddle_x2 >= WALL_R)     state_d = ST_HOLD;
          else if (tick && err <= SB_POS)  state_d = ST_HOLD;
        end
        ST_MOVE_L: begin
          if (bus.paddle_x1 <= 10'd1)      state_d = ST_HOLD;
          else if (tick && err >= SB_NEG)  state_d = ST_HOLD;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    unique case (state_d)
      ST_MOVE_L: cmd_d = 2'd1;
      ST_MOVE_R: cmd_d = 2'd2;
      default:   cmd_d = 2'd0;
    endcase

    // The counter sits at 0 through IDLE, so the first tick is a full period after leaving it.
    if (state_q == ST_IDLE || state_d == ST_IDLE) count_d = '0;
    else if (tick)                                count_d = '0;
    else                                          count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= 2'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      count_q <= count_d;
    end
  end

  assign bus.paddle_cmd = cmd_q;
  assign bus.ai_state   = state_q;

endmodule

// File: tb/tb_paddle_ai_ctrl.sv
// Directed bench for paddle_ai_ctrl: reset, tracking, re-centring, deadband,
// wall stops and forced-idle / reset interruptions.
module tb_paddle_ai_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  paddle_ai_if bus();

  paddle_ai_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One clock; outputs are stable 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pos(input logic appr, input int bx, input int x1, input int x2);
    bus.ball_approaching = appr;
    bus.ball_x           = 10'(bx);
    bus.paddle_x1        = 10'(x1);
    bus.paddle_x2        = 10'(x2);
  endtask

  // Reset, then enable: HOLD lands one edge later with the counter at 0.
  task automatic start_hold(input string name, input logic appr, input int bx,
                            input int x1, input int x2);
    reset = 1'b1; bus.enable = 1'b0; bus.game_end = 1'b0;
    step(); step();
    set_pos(appr, bx, x1, x2);
    reset = 1'b0; bus.enable = 1'b1;
    step();
    checks++;
    if (bus.ai_state !== 2'd1 || bus.paddle_cmd !== 2'd0) begin
      failures++;
      $display("FAIL %s_enter_hold state=%0d cmd=%0d required state=1 cmd=0",
               name, bus.ai_state, bus.paddle_cmd);
    end
  endtask

  // Step n edges; cmd must equal pre_cmd for the first n-1 and post_cmd on the last.
  task automatic run_period(input string name, input int n,
                            input logic [1:0] pre_cmd, input logic [1:0] post_cmd,
                            input logic [1:0] post_state);
    for (int i = 1; i <= n; i++) begin
      step();
      checks++;
      if (i < n) begin
        if (bus.paddle_cmd !== pre_cmd) begin
          failures++;
          $display("FAIL %s_wait edge=%0d cmd=%0d required=%0d", name, i, bus.paddle_cmd, pre_cmd);
        end
      end else if (bus.paddle_cmd !== post_cmd || bus.ai_state !== post_state) begin
        failures++;
        $display("FAIL %s_decide cmd=%0d state=%0d required cmd=%0d state=%0d",
                 name, bus.paddle_cmd, bus.ai_state, post_cmd, post_state);
      end
    end
  endtask

  task automatic check_out(input string name, input logic [1:0] cmd, input logic [1:0] st);
    checks++;
    if (bus.paddle_cmd !== cmd || bus.ai_state !== st) begin
      failures++;
      $display("FAIL %s cmd=%0d state=%0d required cmd=%0d state=%0d",
               name, bus.paddle_cmd, bus.ai_state, cmd, st);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.enable   = 1'($urandom_range(0, 1));
      bus.game_end = 1'($urandom_range(0, 1));
      set_pos(1'($urandom_range(0, 1)), $urandom_range(0, 639),
              $urandom_range(0, 300), $urandom_range(300, 639));
      step();
      check_out("reset", 2'd0, 2'd0);
    end
  endtask

  // centre 335 -> err +165; paddle then walks right 2 px per clock.
  // Tick edge 8m sees err = 165 - 16m: stays >1 through m=10, drops to -11 at m=11 (edge 88).
  task automatic test_track_right();
    int x1, x2;
    start_hold("track", 1'b1, 500, 260, 410);
    run_period("track_start", 8, 2'd0, 2'd2, 2'd3);
    x1 = 260; x2 = 410;
    for (int n = 1; n <= 88; n++) begin
      x1 += 2; x2 += 2;
      bus.paddle_x1 = 10'(x1);
      bus.paddle_x2 = 10'(x2);
      step();
      checks++;
      if (bus.paddle_cmd !== ((n == 88) ? 2'd0 : 2'd2)) begin
        failures++;
        $display("FAIL track_walk edge=%0d cmd=%0d required=%0d",
                 n, bus.paddle_cmd, (n == 88) ? 0 : 2);
      end
    end
    check_out("track_hold", 2'd0, 2'd1);
  endtask

  // Edge 88 was a tick, so the next decision is 8 edges on: centre 475 vs target 320 -> left.
  task automatic test_recentre();
    set_pos(1'b0, 0, 400, 550);
    run_period("recentre_left", 8, 2'd0, 2'd1, 2'd2);
    set_pos(1'b0, 0, 245, 395);
    run_period("recentre_stop", 8, 2'd1, 2'd0, 2'd1);
  endtask

  // err = +3 sits inside the deadband for five ticks.
  task automatic test_deadband();
    start_hold("deadband", 1'b1, 338, 260, 410);
    for (int i = 0; i < 40; i++) begin
      step();
      check_out("deadband_hold", 2'd0, 2'd1);
    end
  endtask

  task automatic test_wall();
    start_hold("wall_r", 1'b1, 600, 400, 500);
    run_period("wall_r_start", 8, 2'd0, 2'd2, 2'd3);
    step(); step(); step();
    check_out("wall_r_moving", 2'd2, 2'd3);
    bus.paddle_x1 = 10'd540; bus.paddle_x2 = 10'd640;
    step();
    check_out("wall_r_stop", 2'd0, 2'd1);

    start_hold("wall_l", 1'b0, 0, 400, 550);
    run_period("wall_l_start", 8, 2'd0, 2'd1, 2'd2);
    step(); step();
    check_out("wall_l_moving", 2'd1, 2'd2);
    bus.paddle_x1 = 10'd1; bus.paddle_x2 = 10'd151;
    step();
    check_out("wall_l_stop", 2'd0, 2'd1);
  endtask

  task automatic test_interrupt();
    start_hold("gend", 1'b0, 0, 400, 550);
    run_period("gend_start", 8, 2'd0, 2'd1, 2'd2);
    step(); step();
    bus.game_end = 1'b1;
    step();
    check_out("gend_idle", 2'd0, 2'd0);
    bus.game_end = 1'b0;
    step();
    check_out("gend_rehold", 2'd0, 2'd1);
    run_period("gend_redecide", 8, 2'd0, 2'd1, 2'd2);

    bus.enable = 1'b0;
    step();
    check_out("disable_idle", 2'd0, 2'd0);
    step();
    check_out("disable_stays", 2'd0, 2'd0);

    start_hold("rst", 1'b1, 600, 300, 400);
    run_period("rst_start", 8, 2'd0, 2'd2, 2'd3);
    step();
    reset = 1'b1;
    step();
    check_out("rst_idle", 2'd0, 2'd0);
    reset = 1'b0;
    step();
    check_out("rst_rehold", 2'd0, 2'd1);
    run_period("rst_redecide", 8, 2'd0, 2'd2, 2'd3);

    // Reset and game_end together: IDLE, and no HOLD while reset stays high even once game_end drops.
    reset = 1'b1; bus.game_end = 1'b1;
    step();
    check_out("both_idle", 2'd0, 2'd0);
    bus.game_end = 1'b0;
    step();
    check_out("reset_wins", 2'd0, 2'd0);
    reset = 1'b0;
    step();
    check_out("both_release", 2'd0, 2'd1);
    run_period("both_redecide", 8, 2'd0, 2'd2, 2'd3);
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.game_end = 1'b0;
    set_pos(1'b0, 0, 0, 0);
    test_reset();
    test_track_right();
    test_recentre();
    test_deadband();
    test_wall();
    test_interrupt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
